// File: rtl/imem_pkg.sv
// Shared encodings and widths for the instruction-memory responder.
package imem_pkg;
  localparam int BLOCK_ADDR_W = 6;
  localparam int WORD_W       = 32;
  localparam int BLOCK_W      = 128;
  localparam int BEATS        = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    DONE     = 2'd2,
    PREFETCH = 2'd3
  } imem_state_e;
endpackage

// File: rtl/imem_beat_timer.sv
// Per-word wait counter plus 4-beat counter, shared by demand fetch and prefetch.
module imem_beat_timer #(
  parameter int WORD_LATENCY = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       run,
  output logic [1:0] beat_idx,
  output logic       beat_done,
  output logic       last_beat
);
  localparam int WC_W = (WORD_LATENCY > 1) ? $clog2(WORD_LATENCY) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WORD_LATENCY - 1);

  logic [WC_W-1:0] wcnt;

  assign beat_done = run && (wcnt == WC_MAX);
  assign last_beat = beat_done && (beat_idx == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt     <= '0;
      beat_idx <= '0;
    end else if (start || abort) begin
      wcnt     <= '0;
      beat_idx <= '0;
    end else if (run) begin
      if (wcnt == WC_MAX) begin
        wcnt     <= '0;
        beat_idx <= beat_idx + 2'd1;
      end else begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-memory block-read responder for the I-cache refill path.
// Define IMEM_PREFETCH_EN to add next-block prefetch into a one-entry buffer.
module inst_mem_responder
  import imem_pkg::*;
#(
  parameter int WORD_LATENCY = 2,
  parameter int BLOCKS       = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    instruct_read,
  input  logic [BLOCK_ADDR_W-1:0] instruct_address,
  output logic                    instruct_busywait,
  output logic [BLOCK_W-1:0]      instruct_readdata
);
  // Preloaded externally; never reset.
  logic [WORD_W-1:0] mem [0:BLOCKS*BEATS-1];

  imem_state_e state, next;
  logic [BLOCK_ADDR_W-1:0] addr_q;
  logic tm_start, tm_abort, tm_run;
  logic [1:0] beat_idx;
  logic beat_done, last_beat;
  logic [WORD_W-1:0] word;

  assign word = mem[{addr_q, beat_idx}];

`ifdef IMEM_PREFETCH_EN
  logic [BLOCK_W-1:0] pf_buf;
  logic pf_valid;
  logic addr_match;
  // addr_q holds the prefetched block's address while the buffer is valid
  assign addr_match = (instruct_address == addr_q);
`endif

  // Busywait tracks read combinationally everywhere except DONE, so no false ready.
  assign instruct_busywait = reset_n && instruct_read && (state != DONE);

  imem_beat_timer #(.WORD_LATENCY(WORD_LATENCY)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (tm_start),
    .abort     (tm_abort),
    .run       (tm_run),
    .beat_idx  (beat_idx),
    .beat_done (beat_done),
    .last_beat (last_beat)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next     = state;
    tm_start = 1'b0;
    tm_abort = 1'b0;
    tm_run   = 1'b0;
    case (state)
      IDLE: begin
        if (instruct_read) begin
`ifdef IMEM_PREFETCH_EN
          if (pf_valid && addr_match) begin
            next = DONE;
          end else begin
            next     = FETCH;
            tm_start = 1'b1;
          end
`else
          next     = FETCH;
          tm_start = 1'b1;
`endif
        end
      end
      FETCH: begin
        if (!instruct_read) begin
          next     = IDLE;
          tm_abort = 1'b1;
        end else begin
          tm_run = 1'b1;
          if (last_beat) next = DONE;
        end
      end
      DONE: begin
`ifdef IMEM_PREFETCH_EN
        next     = PREFETCH;
        tm_start = 1'b1;
`else
        next = IDLE;
`endif
      end
`ifdef IMEM_PREFETCH_EN
      PREFETCH: begin
        if (instruct_read && !addr_match) begin
          next     = FETCH;
          tm_start = 1'b1;
        end else begin
          tm_run = 1'b1;
          if (last_beat) next = instruct_read ? DONE : IDLE;
        end
      end
`endif
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q            <= '0;
      instruct_readdata <= '0;
`ifdef IMEM_PREFETCH_EN
      pf_buf   <= '0;
      pf_valid <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (instruct_read) begin
            addr_q <= instruct_address;
`ifdef IMEM_PREFETCH_EN
            pf_valid <= 1'b0;
            if (pf_valid && addr_match) instruct_readdata <= pf_buf;
`endif
          end
        end
        FETCH: begin
          if (instruct_read && beat_done)
            instruct_readdata[beat_idx*WORD_W +: WORD_W] <= word;
        end
`ifdef IMEM_PREFETCH_EN
        DONE: addr_q <= addr_q + 6'd1;
        PREFETCH: begin
          if (instruct_read && !addr_match) begin
            addr_q   <= instruct_address;
            pf_valid <= 1'b0;
          end else if (beat_done) begin
            pf_buf[beat_idx*WORD_W +: WORD_W] <= word;
            // A claimed prefetch hands the block straight to readdata.
            if (last_beat) begin
              if (instruct_read) instruct_readdata <= {word, pf_buf[3*WORD_W-1:0]};
              else               pf_valid <= 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder; prefetch cases build under IMEM_PREFETCH_EN.
module tb_inst_mem_responder;
  logic         clock = 1'b0;
  logic         reset_n;
  logic         instruct_read;
  logic [5:0]   instruct_address;
  logic         busywait;
  logic [127:0] readdata;

  int checks   = 0;
  int failures = 0;
  int hi;
  logic [127:0] data, data2;
  int hi2;

  inst_mem_responder dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .instruct_read     (instruct_read),
    .instruct_address  (instruct_address),
    .instruct_busywait (busywait),
    .instruct_readdata (readdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_word(int i);
    if ((i >> 2) == 5) return 32'h11111111 * 32'((i & 3) + 1);
    return 32'hC0DE0000 | 32'(i);
  endfunction

  function automatic logic [127:0] exp_blk(logic [5:0] a);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = exp_word(int'(a) * 4 + k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Counts busywait-high cycles from now until DONE, captures readdata in DONE,
  // then steps past the edge ending DONE (read left as is).
  task automatic wait_done(output int n, output logic [127:0] d);
    n = 0;
    #1;
    while (busywait === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    d = readdata;
    tick();
  endtask

  task automatic do_read(input logic [5:0] a, output int n, output logic [127:0] d);
    instruct_read    = 1'b1;
    instruct_address = a;
    wait_done(n, d);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n          = 1'b0;
    instruct_read    = 1'b0;
    instruct_address = '0;
    for (int i = 0; i < 256; i++) dut.mem[i] = exp_word(i);
    #12;
    chk("reset_busywait", 128'(busywait), 128'd0);
    chk("reset_readdata", readdata, 128'd0);
    reset_n = 1'b1;
    tick();

    // Reset during beat 2 of a fetch
    instruct_read    = 1'b1;
    instruct_address = 6'h20;
    repeat (5) tick();
    chk("partial_beats01", readdata, {64'd0, exp_blk(6'h20)[63:0]});
    #2 reset_n = 1'b0;
    #1;
    chk("midfetch_reset_busywait", 128'(busywait), 128'd0);
    chk("midfetch_reset_readdata", readdata, 128'd0);
    instruct_read = 1'b0;
    #2 reset_n = 1'b1;
    tick();
    do_read(6'h20, hi, data);
    instruct_read = 1'b0;
    chk("post_reset_cycles", 128'(hi), 128'd9);
    chk("post_reset_data", data, exp_blk(6'h20));
    repeat (2) tick();

    // Basic read of block 5
    do_read(6'h05, hi, data);
    chk("blk5_cycles", 128'(hi), 128'd9);
    chk("blk5_data", data, 128'h44444444_33333333_22222222_11111111);
    instruct_read = 1'b0;
    chk("blk5_hold", readdata, 128'h44444444_33333333_22222222_11111111);
    repeat (2) tick();

    // Back-to-back 00 then 3F with no dead cycle
    do_read(6'h00, hi, data);
    do_read(6'h3F, hi2, data2);
    instruct_read = 1'b0;
    chk("b2b_first_cycles", 128'(hi), 128'd9);
    chk("b2b_first_data", data, exp_blk(6'h00));
    chk("b2b_second_cycles", 128'(hi2), 128'd9);
    chk("b2b_second_data", data2, exp_blk(6'h3F));
    repeat (2) tick();

    // Read dropped after 3 FETCH cycles
    instruct_read    = 1'b1;
    instruct_address = 6'h07;
    repeat (4) tick();
    instruct_read = 1'b0;
    #1;
    chk("abort_busywait", 128'(busywait), 128'd0);
    tick();
    do_read(6'h02, hi, data);
    instruct_read = 1'b0;
    chk("after_abort_cycles", 128'(hi), 128'd9);
    chk("after_abort_data", data, exp_blk(6'h02));
    repeat (2) tick();

    // Address changes mid-fetch; latched address wins
    instruct_read    = 1'b1;
    instruct_address = 6'h09;
    repeat (3) tick();
    instruct_address = 6'h0A;
    wait_done(hi, data);
    instruct_read = 1'b0;
    chk("addr_change_cycles", 128'(hi + 3), 128'd9);
    chk("addr_change_data", data, exp_blk(6'h09));
    repeat (2) tick();

`ifdef IMEM_PREFETCH_EN
    // Wrap-around prefetch hit
    do_read(6'h3F, hi, data);
    instruct_read = 1'b0;
    repeat (12) tick();
    do_read(6'h00, hi, data);
    instruct_read = 1'b0;
    chk("pf_hit_cycles", 128'(hi), 128'd1);
    chk("pf_hit_data", data, exp_blk(6'h00));
    repeat (2) tick();
    do_read(6'h10, hi, data);
    instruct_read = 1'b0;
    chk("pf_miss_cycles", 128'(hi), 128'd9);
    chk("pf_miss_data", data, exp_blk(6'h10));
    repeat (2) tick();

    // Claim an in-flight prefetch two cycles after DONE
    do_read(6'h04, hi, data);
    instruct_read = 1'b0;
    chk("pf_base_cycles", 128'(hi), 128'd9);
    tick();
    do_read(6'h05, hi, data);
    instruct_read = 1'b0;
    chk("pf_inflight_cycles", 128'(hi), 128'd7);
    chk("pf_inflight_data", data, 128'h44444444_33333333_22222222_11111111);
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
